collision_detect: RTL and testbench

COLLISION_DETECT -- requirements
Module: collision_detect

---
 rtl/collision_detect_pkg.sv | 41 ++++
 rtl/collision_detect_if.sv | 18 +
 rtl/collision_detect_edge_detect.sv | 22 ++
 rtl/collision_detect.sv | 129 ++++++++++++
 tb/tb_collision_detect.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/collision_detect_pkg.sv
// Shared console register map and collision pair bit indices, also used by
// the peripheral bus decoder.
package collision_detect_pkg;

  localparam logic [3:0] REG_CXM0P     = 4'h0;
  localparam logic [3:0] REG_CXM1P     = 4'h1;
  localparam logic [3:0] REG_CXP0FB    = 4'h2;
  localparam logic [3:0] REG_CXP1FB    = 4'h3;
  localparam logic [3:0] REG_CXM0FB    = 4'h4;
  localparam logic [3:0] REG_CXM1FB    = 4'h5;
  localparam logic [3:0] REG_CXBLPF    = 4'h6;
  localparam logic [3:0] REG_CXPPMM    = 4'h7;
  localparam logic [3:0] REG_P0P1_LAST = 4'h8;
  localparam logic [3:0] REG_FRAME     = 4'h9;

  localparam int NUM_PAIRS = 15;

  localparam int PAIR_M0_P1 = 0;
  localparam int PAIR_M0_P0 = 1;
  localparam int PAIR_M1_P0 = 2;
  localparam int PAIR_M1_P1 = 3;
  localparam int PAIR_P0_PF = 4;
  localparam int PAIR_P0_BL = 5;
  localparam int PAIR_P1_PF = 6;
  localparam int PAIR_P1_BL = 7;
  localparam int PAIR_M0_PF = 8;
  localparam int PAIR_M0_BL = 9;
  localparam int PAIR_M1_PF = 10;
  localparam int PAIR_M1_BL = 11;
  localparam int PAIR_BL_PF = 12;
  localparam int PAIR_P0_P1 = 13;
  localparam int PAIR_M0_M1 = 14;

  typedef logic [NUM_PAIRS-1:0] pair_vec_t;

  // Collision registers expose two pair bits in [7:6]
  function automatic logic [7:0] pack_pair(input logic hi, input logic lo);
    return {hi, lo, 6'b000000};
  endfunction

endpackage

// File: rtl/collision_detect_if.sv
// CPU-side register bus of the collision block.
interface collision_detect_if;
  logic       enable;
  logic [3:0] address;
  logic       write_enable;
  logic [7:0] data_out;
  logic       frame_done;

  modport master (
    output enable, address, write_enable,
    input  data_out, frame_done
  );

  modport slave (
    input  enable, address, write_enable,
    output data_out, frame_done
  );
endinterface

// File: rtl/collision_detect_edge_detect.sv
// Registered rising-edge detector: rise pulses for one cycle, one cycle after
// level is first seen high.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/collision_detect.sv
// Sticky object-pair collision latches, per-frame P0/P1 overlap counter and
// CPU read/clear register port.
module collision_detect
  import collision_detect_pkg::*;
(
  input  logic raw_clk,
  input  logic reset,
  input  logic pixel_strobe,
  input  logic in_image,
  input  logic in_vblank,
  input  logic p0,
  input  logic p1,
  input  logic m0,
  input  logic m1,
  input  logic ball,
  input  logic pf,
  collision_detect_if.slave bus
);

  logic       sample;
  logic       cpu_read;
  logic       cpu_clear;
  logic       vblank_rise;
  logic       frame_rd_pending;
  logic       frame_done_q;
  logic [7:0] p0p1_count;
  logic [7:0] p0p1_last;
  logic [7:0] read_value;
  logic [7:0] data_out_q;
  pair_vec_t  latches;
  pair_vec_t  hits;

  assign sample    = pixel_strobe & in_image & ~in_vblank;
  assign cpu_read  = bus.enable & ~bus.write_enable;
  assign cpu_clear = bus.enable & bus.write_enable & (bus.address == REG_CXM0P);

  assign bus.data_out   = data_out_q;
  assign bus.frame_done = frame_done_q;

  edge_detect u_vblank_edge (
    .clk   (raw_clk),
    .rst_n (reset),
    .level (in_vblank),
    .rise  (vblank_rise)
  );

  always_comb begin
    hits = '0;
    if (sample) begin
      hits[PAIR_M0_P1] = m0 & p1;
      hits[PAIR_M0_P0] = m0 & p0;
      hits[PAIR_M1_P0] = m1 & p0;
      hits[PAIR_M1_P1] = m1 & p1;
      hits[PAIR_P0_PF] = p0 & pf;
      hits[PAIR_P0_BL] = p0 & ball;
      hits[PAIR_P1_PF] = p1 & pf;
      hits[PAIR_P1_BL] = p1 & ball;
      hits[PAIR_M0_PF] = m0 & pf;
      hits[PAIR_M0_BL] = m0 & ball;
      hits[PAIR_M1_PF] = m1 & pf;
      hits[PAIR_M1_BL] = m1 & ball;
      hits[PAIR_BL_PF] = ball & pf;
      hits[PAIR_P0_P1] = p0 & p1;
      hits[PAIR_M0_M1] = m0 & m1;
    end
  end

  // A hit on the clearing edge survives the clear
  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      latches <= '0;
    end else begin
      latches <= (cpu_clear ? '0 : latches) | hits;
    end
  end

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      p0p1_count <= 8'h00;
      p0p1_last  <= 8'h00;
    end else if (vblank_rise) begin
      p0p1_last  <= p0p1_count;
      p0p1_count <= 8'h00;
    end else if (sample && p0 && p1 && (p0p1_count != 8'hFF)) begin
      p0p1_count <= p0p1_count + 8'h01;
    end
  end

  // Status read clears the flag one edge later unless a new frame arrives
  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      frame_done_q     <= 1'b0;
      frame_rd_pending <= 1'b0;
    end else begin
      frame_rd_pending <= cpu_read && (bus.address == REG_FRAME);
      if (vblank_rise) begin
        frame_done_q <= 1'b1;
      end else if (frame_rd_pending) begin
        frame_done_q <= 1'b0;
      end
    end
  end

  always_comb begin
    read_value = 8'h00;
    case (bus.address)
      REG_CXM0P:     read_value = pack_pair(latches[PAIR_M0_P1], latches[PAIR_M0_P0]);
      REG_CXM1P:     read_value = pack_pair(latches[PAIR_M1_P0], latches[PAIR_M1_P1]);
      REG_CXP0FB:    read_value = pack_pair(latches[PAIR_P0_PF], latches[PAIR_P0_BL]);
      REG_CXP1FB:    read_value = pack_pair(latches[PAIR_P1_PF], latches[PAIR_P1_BL]);
      REG_CXM0FB:    read_value = pack_pair(latches[PAIR_M0_PF], latches[PAIR_M0_BL]);
      REG_CXM1FB:    read_value = pack_pair(latches[PAIR_M1_PF], latches[PAIR_M1_BL]);
      REG_CXBLPF:    read_value = pack_pair(latches[PAIR_BL_PF], 1'b0);
      REG_CXPPMM:    read_value = pack_pair(latches[PAIR_P0_P1], latches[PAIR_M0_M1]);
      REG_P0P1_LAST: read_value = p0p1_last;
      REG_FRAME:     read_value = {7'b0000000, frame_done_q};
      default:       read_value = 8'h00;
    endcase
  end

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= 8'h00;
    end else if (cpu_read) begin
      data_out_q <= read_value;
    end
  end

endmodule

// File: tb/tb_collision_detect.sv
// Self-checking bench for collision_detect: vector table of single-sample
// collisions plus hand-written multi-cycle sequences, read results via a queue.
module tb_collision_detect;

  logic raw_clk = 1'b0;
  logic reset = 1'b0;
  logic pixel_strobe = 1'b0;
  logic in_image = 1'b0;
  logic in_vblank = 1'b0;
  logic p0 = 1'b0, p1 = 1'b0, m0 = 1'b0, m1 = 1'b0, ball = 1'b0, pf = 1'b0;

  collision_detect_if bus ();

  collision_detect dut (
    .raw_clk      (raw_clk),
    .reset        (reset),
    .pixel_strobe (pixel_strobe),
    .in_image     (in_image),
    .in_vblank    (in_vblank),
    .p0           (p0),
    .p1           (p1),
    .m0           (m0),
    .m1           (m1),
    .ball         (ball),
    .pf           (pf),
    .bus          (bus.slave)
  );

  always #5 raw_clk = ~raw_clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  typedef struct {
    logic [5:0] objs;
    logic [3:0] addr;
    logic [7:0] exp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[14];
  int   total = 0;
  int   bad = 0;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run still active, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge raw_clk);
    #1;
  endtask

  task automatic check_value(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Objects ordered {p0, p1, m0, m1, ball, pf}
  task automatic set_objs(input logic [5:0] objs);
    {p0, p1, m0, m1, ball, pf} = objs;
  endtask

  task automatic drive_pixel(input logic [5:0] objs, input logic image);
    pixel_strobe = 1'b1;
    in_image = image;
    set_objs(objs);
    tick();
    pixel_strobe = 1'b0;
    in_image = 1'b0;
    set_objs(6'b000000);
  endtask

  task automatic do_write(input logic [3:0] addr);
    bus.enable = 1'b1;
    bus.write_enable = 1'b1;
    bus.address = addr;
    tick();
    bus.enable = 1'b0;
    bus.write_enable = 1'b0;
  endtask

  task automatic vblank_pulse();
    in_vblank = 1'b1;
    repeat (3) tick();
    in_vblank = 1'b0;
    tick();
  endtask

  task automatic checkOutput();
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard: got 0x%02h with no expected entry", bus.data_out);
    end else begin
      e = exp_q.pop_front();
      if (bus.data_out !== e.exp) begin
        bad++;
        $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", e.name, bus.data_out, e.exp);
      end
    end
  endtask

  // Issue a read, leave one idle cycle so status clears settle, then compare
  task automatic applyStimulus(input string name, input logic [3:0] addr, input logic [7:0] exp);
    exp_q.push_back('{name: name, exp: exp});
    bus.enable = 1'b1;
    bus.write_enable = 1'b0;
    bus.address = addr;
    tick();
    bus.enable = 1'b0;
    tick();
    checkOutput();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pixel_strobe = 1'b0;
    in_image = 1'b0;
    in_vblank = 1'b0;
    set_objs(6'b000000);
    bus.enable = 1'b0;
    bus.write_enable = 1'b0;
    bus.address = 4'h0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] exp_all [8];

    vecs[0]  = '{6'b101000, 4'h0, 8'h40};
    vecs[1]  = '{6'b011000, 4'h0, 8'h80};
    vecs[2]  = '{6'b100100, 4'h1, 8'h80};
    vecs[3]  = '{6'b010100, 4'h1, 8'h40};
    vecs[4]  = '{6'b100001, 4'h2, 8'h80};
    vecs[5]  = '{6'b100010, 4'h2, 8'h40};
    vecs[6]  = '{6'b010001, 4'h3, 8'h80};
    vecs[7]  = '{6'b001010, 4'h4, 8'h40};
    vecs[8]  = '{6'b000101, 4'h5, 8'h80};
    vecs[9]  = '{6'b000011, 4'h6, 8'h80};
    vecs[10] = '{6'b110000, 4'h7, 8'h80};
    vecs[11] = '{6'b001100, 4'h7, 8'h40};
    vecs[12] = '{6'b100000, 4'h2, 8'h00};
    vecs[13] = '{6'b101000, 4'hA, 8'h00};
    exp_all = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h80, 8'hC0};

    bus.enable = 1'b0;
    bus.write_enable = 1'b0;
    bus.address = 4'h0;
    tick();
    check_value("reset_data_out", bus.data_out, 8'h00);
    check_value("reset_frame_done", {7'b0, bus.frame_done}, 8'h00);
    reset = 1'b1;
    tick();

    $display("[TB] single-pair vectors");
    for (int i = 0; i < 14; i++) begin
      do_write(4'h0);
      drive_pixel(vecs[i].objs, 1'b1);
      applyStimulus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    do_write(4'h0);
    applyStimulus("clear_then_read0", 4'h0, 8'h00);

    $display("[TB] all objects overlap");
    drive_pixel(6'b111111, 1'b1);
    for (int a = 0; a < 8; a++) begin
      applyStimulus($sformatf("all_ones_reg%0d", a), 4'(a), exp_all[a]);
    end

    $display("[TB] off-image strobes");
    do_reset();
    for (int i = 0; i < 100; i++) drive_pixel(6'b110000, 1'b0);
    applyStimulus("off_image_reg7", 4'h7, 8'h00);
    vblank_pulse();
    applyStimulus("off_image_count", 4'h8, 8'h00);
    applyStimulus("off_image_frame", 4'h9, 8'h01);

    $display("[TB] counter saturation");
    do_reset();
    for (int i = 0; i < 300; i++) drive_pixel(6'b110000, 1'b1);
    vblank_pulse();
    check_value("frame_done_port_set", {7'b0, bus.frame_done}, 8'h01);
    applyStimulus("sat_count", 4'h8, 8'hFF);
    applyStimulus("frame_first", 4'h9, 8'h01);
    applyStimulus("frame_second", 4'h9, 8'h00);
    check_value("frame_done_port_clr", {7'b0, bus.frame_done}, 8'h00);
    for (int i = 0; i < 5; i++) drive_pixel(6'b110000, 1'b1);
    vblank_pulse();
    applyStimulus("count_five", 4'h8, 8'h05);

    $display("[TB] clear and set on the same edge");
    do_reset();
    drive_pixel(6'b111111, 1'b1);
    pixel_strobe = 1'b1;
    in_image = 1'b1;
    set_objs(6'b000011);
    do_write(4'h0);
    pixel_strobe = 1'b0;
    in_image = 1'b0;
    set_objs(6'b000000);
    for (int a = 0; a < 10; a++) begin
      applyStimulus($sformatf("clr_set_reg%0d", a), 4'(a), (a == 6) ? 8'h80 : 8'h00);
    end

    $display("[TB] read ordering against same-edge sample");
    do_reset();
    exp_q.push_back('{name: "read_same_edge", exp: 8'h00});
    pixel_strobe = 1'b1;
    in_image = 1'b1;
    set_objs(6'b101000);
    bus.enable = 1'b1;
    bus.write_enable = 1'b0;
    bus.address = 4'h0;
    tick();
    bus.enable = 1'b0;
    pixel_strobe = 1'b0;
    in_image = 1'b0;
    set_objs(6'b000000);
    tick();
    checkOutput();
    applyStimulus("read_next", 4'h0, 8'h40);

    $display("[TB] writes to other addresses");
    do_reset();
    drive_pixel(6'b100100, 1'b1);
    applyStimulus("m1p0_read", 4'h1, 8'h80);
    do_write(4'h5);
    check_value("write_keeps_data_out", bus.data_out, 8'h80);
    applyStimulus("m1p0_after_wr5", 4'h1, 8'h80);
    do_write(4'h0);
    check_value("clear_keeps_data_out", bus.data_out, 8'h80);
    applyStimulus("m1p0_after_clr", 4'h1, 8'h00);

    $display("[TB] reset mid-frame");
    do_reset();
    drive_pixel(6'b111111, 1'b1);
    for (int i = 0; i < 6; i++) drive_pixel(6'b110000, 1'b1);
    applyStimulus("pre_reset_reg0", 4'h0, 8'hC0);
    reset = 1'b0;
    #1;
    check_value("reset_async_data_out", bus.data_out, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    for (int a = 0; a < 10; a++) begin
      applyStimulus($sformatf("post_reset_reg%0d", a), 4'(a), 8'h00);
    end
    for (int i = 0; i < 3; i++) drive_pixel(6'b110000, 1'b1);
    vblank_pulse();
    applyStimulus("fresh_count", 4'h8, 8'h03);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
